mct_burst_issuer: RTL and testbench
===================================

// Module: mct_burst_issuer
// PURPOSE
//  Splits one host-programmed transfer (start address, length in beats) into fixed-size burst
//  requests on a valid/ready request channel.
//  Limits the number of in-flight bursts and retires one burst per completion pulse.
//  Signals done once every burst has been issued and completed.
//  Sits between the kernel control FSM and the memory-master address channel.
// PARAMETERS
//  C_ADDR_WIDTH       64  byte-address width
//  C_LEN_WIDTH        32  transfer length width, in beats
//  C_BYTES_PER_BEAT   64  data-bus bytes per beat; power of 2
//  C_BURST_LEN        64  max beats per burst; power of 2, 1..256
//  C_MAX_OUTSTANDING  16  max issued-but-uncompleted bursts; >=1
// PORTS
//  clk            in   1                  clock; all logic rising-edge
//  rst            in   1                  synchronous reset, active-high
//  ctrl_start     in   1                  start pulse; sampled only in IDLE
//  ctrl_addr      in   C_ADDR_WIDTH       start byte address; must be aligned to C_BURST_LEN*C_BYTES_PER_BEAT
//  ctrl_len       in   C_LEN_WIDTH        transfer length in beats; 0 is legal
//  ctrl_busy      out  1                  high from the cycle after an accepted start until done
//  ctrl_done      out  1                  one-cycle pulse on completion
//  req_valid      out  1                  burst request valid
//  req_ready      in   1                  burst request accepted
//  req_addr       out  C_ADDR_WIDTH       burst byte address
//  req_len        out  8                  beats-1 of this burst (AXI len encoding)
//  cpl_valid      in   1                  one-cycle pulse per completed burst
//  outstanding    out  clog2(C_MAX_OUTSTANDING)+1  current in-flight burst count
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; FSM IDLE; remaining = 0; outstanding = 0.
//   - rst asserted mid-transfer abandons the transfer and gives no done pulse.
//   - Completions for bursts issued before reset are not tracked.
//  FSM states IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//   - IDLE:
//     - on ctrl_start, latch addr/len and go to ISSUE (len>0) or DONE (len==0).
//     - ctrl_start outside IDLE is ignored.
//   - ISSUE:
//     - req_valid = 1 while remaining>0 and outstanding<C_MAX_OUTSTANDING.
//     - Once req_valid is asserted, it and the payload stay stable until req_ready.
//     - req_len = min(remaining, C_BURST_LEN)-1.
//     - On handshake: addr += C_BURST_LEN*C_BYTES_PER_BEAT; remaining -= beats issued.
//     - The last handshake (remaining reaches 0) moves the FSM to DRAIN.
//   - DRAIN: wait until outstanding==0, counting any completion in the same cycle, then go to DONE.
//   - DONE: ctrl_done=1 for exactly one cycle, then IDLE.
//   - ctrl_busy = 1 in ISSUE and DRAIN only.
//  Outstanding count:
//   - +1 on req handshake, -1 on cpl_valid.
//   - Both in the same cycle: count unchanged.
//   - Value registered; output equals the register.
//   - Gating uses the registered value. At C_MAX_OUTSTANDING with cpl_valid high, req_valid rises the next cycle, not the same cycle.
//   - cpl_valid while outstanding==0 is a protocol error: count holds at 0 and an assertion fires.
//   - Count never wraps.
//  Final burst may be short, e.g. len=130, C_BURST_LEN=64 gives bursts of 64, 64, 2 beats.
//  Latency: first req_valid 1 cycle after the start is accepted; len==0 gives done 2 cycles after start.
// STRUCTURE
//  Shared package mct_pkg holds:
//   - state enum (IDLE, ISSUE, DRAIN, DONE);
//   - localparams for burst byte stride and outstanding-count width.
//  One sub-module: the team's standard up/down counter (load unused).
//   - C_WIDTH = clog2(C_MAX_OUTSTANDING)+1.
//   - incr = handshake, decr = cpl_valid.
//   - is_zero drives the DRAIN exit.
//  Remaining-beat and address registers plus FSM sit in this module.
// TESTING
//  1. len=0 start -> no req_valid; ctrl_done pulse 2 cycles after start; ctrl_busy stays 0.
//  2. addr=0x1000, len=130, ready=1, immediate cpl -> 3 reqs: (0x1000,63), (0x2000,63), (0x3000,1); single done pulse.
//  3. MAX_OUTSTANDING=2, len=256, cpl withheld -> exactly 2 reqs, req_valid low, outstanding=2; one cpl -> req_valid returns next cycle.
//  4. req_ready held low 10 cycles -> req_valid, req_addr, req_len stable all 10 cycles.
//  5. Handshake and cpl_valid in the same cycle at outstanding=1 -> outstanding stays 1.
//  6. rst mid-ISSUE -> next cycle all outputs 0, IDLE; new start runs cleanly. Bench also checks ctrl_start while busy is ignored.

Source files
------------

// File: rtl/mct_pkg.sv
// Shared types and sizing helpers for the memory-channel burst issuer.
package mct_pkg;

    // Transfer sequencing: accept, issue bursts, wait for completions, report.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Default geometry of the memory master this block normally feeds.
    localparam int C_DEF_ADDR_WIDTH      = 64;
    localparam int C_DEF_LEN_WIDTH       = 32;
    localparam int C_DEF_BYTES_PER_BEAT  = 64;
    localparam int C_DEF_BURST_LEN       = 64;
    localparam int C_DEF_MAX_OUTSTANDING = 16;

    // Byte distance between consecutive burst start addresses.
    function automatic int stride_bytes(input int burst_len, input int bytes_per_beat);
        return burst_len * bytes_per_beat;
    endfunction

    // Width that holds 0..max_outstanding inclusive.
    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding) + 1;
    endfunction

endpackage

// File: rtl/mct_burst_issuer_counter.sv
// Saturating up/down counter with parallel load and a zero flag.
module mct_burst_issuer_counter #(
    parameter int C_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [C_WIDTH-1:0] i_load_val,
    input  logic               i_incr,
    input  logic               i_decr,
    output logic [C_WIDTH-1:0] o_count,
    output logic               o_is_zero
);

    logic [C_WIDTH-1:0] r_count;

    // Count register: simultaneous up and down cancel; both ends saturate instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: state registers take non-blocking assignments so every flop samples the pre-edge values.
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_incr && !i_decr) begin
            if (r_count != '1) begin
                r_count <= r_count + C_WIDTH'(1);
            end
        end else if (i_decr && !i_incr) begin
            if (r_count != '0) begin
                r_count <= r_count - C_WIDTH'(1);
            end
        end
    end

    assign o_count   = r_count;
    assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/mct_burst_issuer.sv
// Splits one programmed transfer into fixed-size burst requests, bounds the
// number of bursts in flight and reports completion once all have retired.
module mct_burst_issuer
    import mct_pkg::*;
#(
    parameter int C_ADDR_WIDTH      = C_DEF_ADDR_WIDTH,
    parameter int C_LEN_WIDTH       = C_DEF_LEN_WIDTH,
    parameter int C_BYTES_PER_BEAT  = C_DEF_BYTES_PER_BEAT,
    parameter int C_BURST_LEN       = C_DEF_BURST_LEN,
    parameter int C_MAX_OUTSTANDING = C_DEF_MAX_OUTSTANDING
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]                  ctrl_addr,
    input  logic [C_LEN_WIDTH-1:0]                   ctrl_len,
    output logic                                     ctrl_busy,
    output logic                                     ctrl_done,
    output logic                                     req_valid,
    input  logic                                     req_ready,
    output logic [C_ADDR_WIDTH-1:0]                  req_addr,
    output logic [7:0]                               req_len,
    input  logic                                     cpl_valid,
    output logic [cnt_width(C_MAX_OUTSTANDING)-1:0]  outstanding
);

    localparam int                      LP_CNT_W     = cnt_width(C_MAX_OUTSTANDING);
    localparam logic [C_LEN_WIDTH-1:0]  LP_BURST     = C_LEN_WIDTH'(C_BURST_LEN);
    localparam logic [C_ADDR_WIDTH-1:0] LP_STRIDE    = C_ADDR_WIDTH'(stride_bytes(C_BURST_LEN, C_BYTES_PER_BEAT));
    localparam logic [LP_CNT_W-1:0]     LP_MAX_OUT   = LP_CNT_W'(C_MAX_OUTSTANDING);
    localparam logic [LP_CNT_W-1:0]     LP_ONE       = LP_CNT_W'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_LEN_WIDTH-1:0]  r_remaining;
    logic                    r_done;

    logic [C_LEN_WIDTH-1:0]  w_beats;
    logic                    w_req_valid;
    logic                    w_handshake;
    logic                    w_last_burst;
    logic                    w_drain_exit;
    logic [LP_CNT_W-1:0]     w_count;
    logic                    w_is_zero;

    // Beats in the burst currently offered: a full burst, or whatever is left.
    assign w_beats = (r_remaining >= LP_BURST) ? LP_BURST : r_remaining;

    // Gating reads the registered count, so a completion at the limit frees
    // a slot one cycle later. Nothing in the valid term can fall without a
    // handshake, which keeps the request stable while it waits for ready.
    assign w_req_valid  = (r_state == S_ISSUE) && (r_remaining != '0) && (w_count < LP_MAX_OUT);
    assign w_handshake  = w_req_valid && req_ready;
    assign w_last_burst = (r_remaining == w_beats);

    // Leave DRAIN as soon as the count will be zero after this edge.
    assign w_drain_exit = w_is_zero || ((w_count == LP_ONE) && cpl_valid);

    mct_burst_issuer_counter #(
        .C_WIDTH    (LP_CNT_W)
    ) u_outstanding (
        .clk        (clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_incr     (w_handshake),
        .i_decr     (cpl_valid),
        .o_count    (w_count),
        .o_is_zero  (w_is_zero)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the state-derived busy flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        ctrl_busy   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ctrl_start) begin
                    w_state_nxt = (ctrl_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                ctrl_busy = 1'b1;
                if (w_handshake && w_last_burst) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                ctrl_busy = 1'b1;
                if (w_drain_exit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Transfer address/length tracking and the registered done pulse.
    always_ff @(posedge clk) begin
        // NOTE: every register here is reset, so all outputs read zero the cycle after rst.
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            // The pulse leaves a flop one cycle after the FSM passes through DONE.
            r_done <= (r_state == S_DONE);
            if ((r_state == S_IDLE) && ctrl_start) begin
                r_addr      <= ctrl_addr;
                r_remaining <= ctrl_len;
            end else if (w_handshake) begin
                r_addr      <= r_addr + LP_STRIDE;
                r_remaining <= r_remaining - w_beats;
            end
        end
    end

    assign req_valid   = w_req_valid;
    assign req_addr    = r_addr;
    // Report 0 rather than all-ones when nothing is left, so an idle block reads zero.
    assign req_len     = (w_beats == '0) ? 8'd0 : 8'(w_beats - LP_ONE_LEN());
    assign ctrl_done   = r_done;
    assign outstanding = w_count;

    function automatic logic [C_LEN_WIDTH-1:0] LP_ONE_LEN();
        return C_LEN_WIDTH'(1);
    endfunction

    // A completion with nothing in flight means the memory side lost track of its bursts.
    a_no_cpl_underflow: assert property (@(posedge clk) disable iff (rst) !(cpl_valid && w_is_zero));

endmodule

// File: tb/tb_mct_burst_issuer.sv
// Self-checking bench for mct_burst_issuer: a transfer-level reference model
// (burst list + in-flight count + done timing) compared every cycle, directed
// scenarios with literal expectations, then randomized transfers.
module tb_mct_burst_issuer;

    localparam int MAX_OUT = 2;
    localparam int BURST   = 64;
    localparam logic [63:0] STRIDE = 64'h1000;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic        clk;
    logic        rst;
    logic        ctrl_start;
    logic [63:0] ctrl_addr;
    logic [31:0] ctrl_len;
    logic        ctrl_busy;
    logic        ctrl_done;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic        cpl_valid;
    logic [1:0]  outstanding;

    mct_burst_issuer #(
        .C_ADDR_WIDTH      (64),
        .C_LEN_WIDTH       (32),
        .C_BYTES_PER_BEAT  (64),
        .C_BURST_LEN       (BURST),
        .C_MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_start  (ctrl_start),
        .ctrl_addr   (ctrl_addr),
        .ctrl_len    (ctrl_len),
        .ctrl_busy   (ctrl_busy),
        .ctrl_done   (ctrl_done),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .cpl_valid   (cpl_valid),
        .outstanding (outstanding)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    burst_t q[$];
    int     m_inflight  = 0;
    bit     m_busy      = 0;
    bit     m_live      = 0;
    int     cyc         = 0;
    int     m_donestate = -5;
    int     m_done_cyc  = -5;

    // Stimulus controls and observation logs
    int     ready_mode = 0;   // 0 low, 1 high, 2 random
    int     cpl_mode   = 0;   // 0 none, 1 as soon as possible, 2 random
    bit     cpl_force  = 0;
    burst_t log_q[$];
    int     done_cnt   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void build_bursts(input logic [63:0] a, input logic [31:0] l);
        logic [63:0] addr = a;
        longint      rem  = longint'(l);
        while (rem > 0) begin
            burst_t b;
            int beats = (rem > BURST) ? BURST : int'(rem);
            b.addr = addr;
            b.len  = 8'(beats - 1);
            q.push_back(b);
            addr += STRIDE;
            rem  -= beats;
        end
    endfunction

    // Model: advance the transfer by the inputs seen at this edge.
    always @(posedge clk) begin : model
        bit hs;
        bit idle_prev;
        if (rst) begin
            q.delete();
            m_inflight  = 0;
            m_busy      = 0;
            m_donestate = -5;
            m_done_cyc  = -5;
            m_live      = 1;
        end else begin
            idle_prev = !m_busy && (cyc != m_donestate);
            hs = m_busy && (q.size() > 0) && (m_inflight < MAX_OUT) && req_ready;
            if (hs) void'(q.pop_front());
            m_inflight = m_inflight + int'(hs) - int'(cpl_valid);
            if (m_inflight < 0) m_inflight = 0;
            if (m_busy && (q.size() == 0) && (m_inflight == 0)) begin
                m_busy      = 0;
                m_donestate = cyc + 1;
                m_done_cyc  = cyc + 2;
            end
            if (idle_prev && ctrl_start) begin
                if (ctrl_len == 0) begin
                    m_donestate = cyc + 1;
                    m_done_cyc  = cyc + 2;
                end else begin
                    build_bursts(ctrl_addr, ctrl_len);
                    m_busy = 1;
                end
            end
        end
        cyc++;
    end

    // Compare: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (m_live) begin
            bit exp_v;
            exp_v = m_busy && (q.size() > 0) && (m_inflight < MAX_OUT);
            check("req_valid", req_valid, exp_v);
            if (exp_v) begin
                check("req_addr", req_addr, q[0].addr);
                check("req_len", req_len, q[0].len);
            end
            check("outstanding", outstanding, m_inflight);
            check("ctrl_busy", ctrl_busy, m_busy);
            check("ctrl_done", ctrl_done, cyc == m_done_cyc);
        end
    end

    // Monitor: log accepted requests and count done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                burst_t b;
                b.addr = req_addr;
                b.len  = req_len;
                log_q.push_back(b);
            end
            if (ctrl_done) done_cnt++;
        end
    end

    // Driver: memory-side ready and completions, late in the cycle.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       req_ready = 1'b0;
            1:       req_ready = 1'b1;
            default: req_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (cpl_mode)
            0:       cpl_valid = cpl_force;
            1:       cpl_valid = cpl_force || (m_inflight > 0);
            default: cpl_valid = cpl_force || ((m_inflight > 0) && ($urandom_range(0, 2) == 0));
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [63:0] a, input logic [31:0] l);
        ctrl_start = 1'b1;
        ctrl_addr  = a;
        ctrl_len   = l;
        @(posedge clk);
        #1;
        ctrl_start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget);
        int n = 0;
        while ((done_cnt == c0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("done_within_budget", done_cnt != c0, 1'b1);
    endtask

    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int c0;
        logic [63:0] a;
        logic [31:0] l;

        rst        = 1'b1;
        ctrl_start = 1'b0;
        ctrl_addr  = '0;
        ctrl_len   = '0;
        req_ready  = 1'b0;
        cpl_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_busy", ctrl_busy, 1'b0);
        check("rst_done", ctrl_done, 1'b0);
        check("rst_outstanding", outstanding, 2'd0);
        check("rst_req_addr", req_addr, 64'h0);
        check("rst_req_len", req_len, 8'h0);
        step(1);

        // Zero-length transfer: done two cycles after start, never busy
        c0 = done_cnt;
        start_xfer(64'h5000, 32'd0);
        @(negedge clk);
        check("len0_no_done_yet", ctrl_done, 1'b0);
        check("len0_not_busy", ctrl_busy, 1'b0);
        check("len0_no_req", req_valid, 1'b0);
        @(negedge clk);
        check("len0_done_pulse", ctrl_done, 1'b1);
        check("len0_not_busy2", ctrl_busy, 1'b0);
        @(negedge clk);
        check("len0_done_once", ctrl_done, 1'b0);
        step(1);

        // 130 beats: 64 + 64 + 2, immediate completions
        ready_mode = 1;
        cpl_mode   = 1;
        log_q.delete();
        c0 = done_cnt;
        start_xfer(64'h1000, 32'd130);
        wait_done(c0, 200);
        step(3);
        check("t2_req_count", log_q.size(), 3);
        if (log_q.size() > 0) begin
            check("t2_addr0", log_q[0].addr, 64'h1000);
            check("t2_len0", log_q[0].len, 8'd63);
        end
        if (log_q.size() > 1) begin
            check("t2_addr1", log_q[1].addr, 64'h2000);
            check("t2_len1", log_q[1].len, 8'd63);
        end
        if (log_q.size() > 2) begin
            check("t2_addr2", log_q[2].addr, 64'h3000);
            check("t2_len2", log_q[2].len, 8'd1);
        end
        check("t2_single_done", done_cnt - c0, 1);

        // Outstanding limit with completions withheld
        ready_mode = 1;
        cpl_mode   = 0;
        log_q.delete();
        c0 = done_cnt;
        start_xfer(64'h0, 32'd256);
        step(10);
        @(negedge clk);
        check("t3_req_count", log_q.size(), 2);
        check("t3_valid_low", req_valid, 1'b0);
        check("t3_outstanding", outstanding, 2'd2);
        step(1);
        cpl_force = 1'b1;
        @(negedge clk);
        check("t3_valid_same_cycle", req_valid, 1'b0);
        step(1);
        cpl_force = 1'b0;
        @(negedge clk);
        check("t3_valid_next_cycle", req_valid, 1'b1);
        check("t3_addr_next", req_addr, 64'h2000);
        step(1);
        cpl_mode = 1;
        wait_done(c0, 400);
        step(2);

        // Backpressure: payload held while ready stays low
        ready_mode = 0;
        cpl_mode   = 1;
        c0 = done_cnt;
        start_xfer(64'h40000, 32'd100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_valid_held", req_valid, 1'b1);
            check("t4_addr_held", req_addr, 64'h40000);
            check("t4_len_held", req_len, 8'd63);
        end
        step(1);
        ready_mode = 1;
        wait_done(c0, 200);
        step(2);

        // Handshake and completion in the same cycle at outstanding 1
        ready_mode = 1;
        cpl_mode   = 1;
        c0 = done_cnt;
        start_xfer(64'h8000, 32'd128);
        @(negedge clk);
        check("t5_out_start", outstanding, 2'd0);
        @(negedge clk);
        check("t5_out_one", outstanding, 2'd1);
        @(negedge clk);
        check("t5_hs_and_cpl", outstanding, 2'd1);
        step(1);
        wait_done(c0, 200);
        step(2);

        // Start while busy is ignored; reset mid-ISSUE abandons the transfer
        ready_mode = 0;
        cpl_mode   = 0;
        start_xfer(64'h10000, 32'd300);
        step(2);
        start_xfer(64'h99000, 32'd5);
        log_q.delete();
        ready_mode = 1;
        step(4);
        ready_mode = 0;
        @(negedge clk);
        check("t6_req_count", log_q.size(), 2);
        if (log_q.size() > 1) begin
            check("t6_addr0", log_q[0].addr, 64'h10000);
            check("t6_addr1", log_q[1].addr, 64'h11000);
        end
        c0 = done_cnt;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", req_valid, 1'b0);
        check("t6_rst_busy", ctrl_busy, 1'b0);
        check("t6_rst_done", ctrl_done, 1'b0);
        check("t6_rst_outstanding", outstanding, 2'd0);
        check("t6_rst_addr", req_addr, 64'h0);
        check("t6_rst_len", req_len, 8'h0);
        step(3);
        check("t6_no_done_after_rst", done_cnt - c0, 0);
        ready_mode = 1;
        cpl_mode   = 1;
        log_q.delete();
        c0 = done_cnt;
        start_xfer(64'h20000, 32'd64);
        wait_done(c0, 200);
        step(2);
        check("t6_restart_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("t6_restart_addr", log_q[0].addr, 64'h20000);
            check("t6_restart_len", log_q[0].len, 8'd63);
        end

        // Randomized transfers under random ready/completion timing
        ready_mode = 2;
        cpl_mode   = 2;
        for (int t = 0; t < 20; t++) begin
            a = {$urandom(), $urandom()};
            a[11:0] = 12'h0;
            case ($urandom_range(0, 5))
                0:       l = 32'd0;
                1:       l = $urandom_range(1, 63);
                2:       l = 32'd64;
                3:       l = $urandom_range(65, 127);
                4:       l = 32'd128;
                default: l = $urandom_range(129, 320);
            endcase
            c0 = done_cnt;
            start_xfer(a, l);
            start_xfer({$urandom(), 32'h0}, $urandom_range(0, 200));
            wait_done(c0, 3000);
            step($urandom_range(0, 3));
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
